data_memory_ctrl: RTL and testbench

Parametrised, byte-addressable, little-endian data memory for the RISC-V core's load/store stage. Supports byte, half and word accesses with sign/zero extension for loads. Uses a valid/ready request and response handshake with configurable read latency. Flags misaligned and out-of-range accesses instead of corrupting memory.

---
 rtl/riscv_mem_pkg.sv | 28 ++
 rtl/load_extend.sv | 35 +++
 rtl/data_memory_ctrl.sv | 174 +++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the load/store data memory path: access-size
// encodings, the controller state enum and a size-to-byte-count helper.
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Bytes touched by an access. Size 3 is illegal and is flagged elsewhere;
    // it reports 4 so range checks on it stay conservative.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MEM_B:   return 3'd1;
            MEM_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load-data formatter: takes the little-endian raw word read
// from the addressed byte upward and returns the byte/half/word result,
// zero- or sign-extended to 32 bits.
//   raw         in  32  raw bytes, raw[7:0] = byte at the access address
//   size        in  2   MEM_B / MEM_H / MEM_W (3 gives 0)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  extended load value
// -----------------------------------------------------------------------------
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic sign_b;
    logic sign_h;

    always_comb begin
        sign_b = raw[7]  & ~is_unsigned;
        sign_h = raw[15] & ~is_unsigned;
        result = 32'h0;
        case (size)
            MEM_B:   result = {{24{sign_b}}, raw[7:0]};
            MEM_H:   result = {{16{sign_h}}, raw[15:0]};
            MEM_W:   result = raw;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
// Byte-addressable little-endian data memory for the load/store stage.
// One transaction outstanding at a time; response after RD_LATENCY cycles.
// Misaligned, out-of-range and size-3 accesses return rsp_err=1 with zero
// data and never touch memory.
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake
//   req_we                 1 = store, 0 = load
//   req_size               0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned           zero-extend loads when 1
//   req_addr  [ADDR_W]     byte address
//   req_wdata [32]         store data (low bytes for byte/half)
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata [32]         extended load data, 0 for stores and errors
//   rsp_err                access error flag
// -----------------------------------------------------------------------------
module data_memory_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 10240,
    parameter int ADDR_W      = 32,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = 3;

    // Storage: not reset.
    logic [7:0] mem [DEPTH_BYTES];

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic [2:0]        nbytes;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_size;
    logic              req_err;
    logic [ADDR_W:0]   last_addr;
    logic [IDX_W-1:0]  byte_idx [4];
    logic [31:0]       raw_word;
    logic [31:0]       ext_word;

    assign accept = req_valid && req_ready;

    // -------------------------------------------------------------------------
    // Access checks, evaluated on the request fields at the accept edge (the
    // same values that get captured).
    // -------------------------------------------------------------------------
    always_comb begin
        nbytes       = size_bytes(req_size);
        bad_size     = (req_size == 2'd3);
        misaligned   = ((req_size == MEM_H) && req_addr[0]) ||
                       ((req_size == MEM_W) && (req_addr[1:0] != 2'b00));
        // One extra bit so addresses near the top of the space cannot wrap.
        last_addr    = {1'b0, req_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
        out_of_range = (last_addr >= (ADDR_W+1)'(DEPTH_BYTES));
        req_err      = bad_size || misaligned || out_of_range;
    end

    // -------------------------------------------------------------------------
    // Byte lanes: lane k addresses req_addr+k. Lanes past the end of the array
    // read as 0; such accesses are always flagged, so the value is discarded.
    // -------------------------------------------------------------------------
    always_comb begin
        raw_word = 32'h0;
        for (int k = 0; k < 4; k++) begin
            byte_idx[k] = req_addr[IDX_W-1:0] + IDX_W'(k);
            if (int'(byte_idx[k]) < DEPTH_BYTES)
                raw_word[8*k +: 8] = mem[byte_idx[k]];
        end
    end

    load_extend u_load_extend (
        .raw         (raw_word),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .result      (ext_word)
    );

    // Stores commit on the accept edge; only the addressed bytes change.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < nbytes)
                    mem[byte_idx[k]] <= req_wdata[8*k +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. Load data is captured at accept, so a response always
    // reflects memory as it was at acceptance.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_err_d   = req_err;
                    rsp_rdata_d = (req_err || req_we) ? 32'h0 : ext_word;
                    if (RD_LATENCY <= 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(RD_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                // WAIT lasts RD_LATENCY-1 cycles; leave as cnt hits zero.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
// Directed vectors with hand-computed expectations for data_memory_ctrl,
// built with RD_LATENCY=3.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;
    import riscv_mem_pkg::*;

    localparam int DEPTH = 10240;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (32),
        .RD_LATENCY  (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request, wait for it to be accepted, then wait for and
    // consume the response with rsp_ready high. lat = cycles accept->valid.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'bx; req_size = 2'bxx; req_addr = 'x; req_wdata = 'x;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
    endtask

    task automatic ld(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, sz, uns, addr, 32'h0, rd, er, lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 32'(er), 32'(exp_er));
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    endtask

    task automatic st(input string tag, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd, input logic exp_er);
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, sz, 1'b0, addr, wd, rd, er, lat);
        chk({tag, "_rdata"}, rd, 32'h0);
        chk({tag, "_err"}, 32'(er), 32'(exp_er));
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int seen;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err",   32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        // Word store and differently sized loads of it
        st("sw10",  MEM_W, 32'h10, 32'hDEADBEEF, 1'b0);
        ld("lw10",  MEM_W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        ld("lbu10", MEM_B, 1'b1, 32'h10, 32'h000000EF, 1'b0);
        ld("lb13",  MEM_B, 1'b0, 32'h13, 32'hFFFFFFDE, 1'b0);
        ld("lb10",  MEM_B, 1'b0, 32'h10, 32'hFFFFFFEF, 1'b0);
        ld("lhu12", MEM_H, 1'b1, 32'h12, 32'h0000DEAD, 1'b0);

        // Half store touches only its two bytes
        st("sw20",  MEM_W, 32'h20, 32'h11223344, 1'b0);
        st("sh22",  MEM_H, 32'h22, 32'h00008001, 1'b0);
        ld("lh22",  MEM_H, 1'b0, 32'h22, 32'hFFFF8001, 1'b0);
        ld("lhu22", MEM_H, 1'b1, 32'h22, 32'h00008001, 1'b0);
        ld("lw20",  MEM_W, 1'b0, 32'h20, 32'h80013344, 1'b0);
        st("sb21",  MEM_B, 32'h21, 32'hFFFFFF7E, 1'b0);
        ld("lw20b", MEM_W, 1'b0, 32'h20, 32'h80017E44, 1'b0);

        // Misaligned / illegal size: flagged, memory untouched
        ld("lw11",  MEM_W, 1'b0, 32'h11, 32'h0, 1'b1);
        ld("lh13",  MEM_H, 1'b0, 32'h13, 32'h0, 1'b1);
        st("sw12",  MEM_W, 32'h12, 32'hCAFEF00D, 1'b1);
        st("ss3",   2'd3,  32'h10, 32'h12345678, 1'b1);
        ld("ls3",   2'd3,  1'b0, 32'h10, 32'h0, 1'b1);
        ld("lw10b", MEM_W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

        // Top of memory and out of range
        st("sh_top",  MEM_H, DEPTH-2, 32'h0000A5C3, 1'b0);
        ld("lhu_top", MEM_H, 1'b1, DEPTH-2, 32'h0000A5C3, 1'b0);
        st("sb_last", MEM_B, DEPTH-1, 32'h0000007F, 1'b0);
        ld("lb_last", MEM_B, 1'b0, DEPTH-1, 32'h0000007F, 1'b0);
        ld("lh_top",  MEM_H, 1'b0, DEPTH-2, 32'h00007FC3, 1'b0);
        ld("lw_m2",   MEM_W, 1'b0, DEPTH-2, 32'h0, 1'b1);
        ld("lw_depth",MEM_W, 1'b0, DEPTH,   32'h0, 1'b1);
        ld("lb_depth",MEM_B, 1'b0, DEPTH,   32'h0, 1'b1);
        ld("lw_hi",   MEM_W, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b1);
        st("sw_oor",  MEM_W, DEPTH, 32'h1, 1'b1);

        // Back-pressure: response held stable while rsp_ready is low
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = MEM_W; req_unsigned = 1'b0;
        req_addr = 32'h10; rsp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 1;
        while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
        chk("stall_lat", 32'(guard), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("stall_err",   32'(rsp_err), 32'd0);
            chk("stall_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_done_valid", 32'(rsp_valid), 32'd0);
        chk("stall_done_ready", 32'(req_ready), 32'd1);

        // Reset during WAIT: response discarded, accepted store kept
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = MEM_W; req_addr = 32'h30;
        req_wdata = 32'h12345678; rsp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_in_wait", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("mid_no_rsp", 32'(seen), 32'd0);
        ld("lw30", MEM_W, 1'b0, 32'h30, 32'h12345678, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
